// File: rtl/multi_key_in.sv
// N-channel key input: synchronise, debounce, press/release pulses.
// Optional auto-repeat of keypress when KEY_AUTOREPEAT_EN is defined.
module multi_key_in #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] key_raw,
  output logic [N-1:0] key_state,
  output logic [N-1:0] keypress,
  output logic [N-1:0] keyrelease,
  output logic         any_press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (N < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("multi_key_in: illegal parameter value");
  end

  logic [N-1:0]  r_sync [SYNC_STAGES];
  logic [N-1:0]  r_state;
  logic [N-1:0]  r_press;
  logic [N-1:0]  r_rel;
  logic [CW-1:0] r_cnt [N];

  logic [N-1:0]  w_s;
  logic [N-1:0]  w_diff;
  logic [N-1:0]  w_acc;
  logic [N-1:0]  w_rep;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < SYNC_STAGES; j++)
        r_sync[j] <= '0;
    end else begin
      r_sync[0] <= key_raw;
      for (int j = 1; j < SYNC_STAGES; j++)
        r_sync[j] <= r_sync[j-1];
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = w_s ^ r_state;

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < N; i++)
      w_acc[i] = w_diff[i] && (r_cnt[i] == CNT_MAX);
  end

  // A mismatch must survive DEBOUNCE_CYCLES edges in a row to be accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= '0;
      for (int i = 0; i < N; i++)
        r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!w_diff[i] || w_acc[i])
          r_cnt[i] <= '0;
        else
          r_cnt[i] <= r_cnt[i] + 1'b1;
        if (w_acc[i])
          r_state[i] <= w_s[i];
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX) + 1;
  localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_RAT = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] r_rep [N];

  // A pending release wins over a repeat falling on the same edge
  always_comb begin
    w_rep = '0;
    for (int i = 0; i < N; i++)
      w_rep[i] = r_state[i] && !w_acc[i] && (r_rep[i] == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++)
        r_rep[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_acc[i] && w_s[i])
          r_rep[i] <= R_DLY;
        else if (!r_state[i] || w_acc[i])
          r_rep[i] <= '0;
        else if (r_rep[i] == '0)
          r_rep[i] <= R_RAT;
        else
          r_rep[i] <= r_rep[i] - 1'b1;
      end
    end
  end
`else
  assign w_rep = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_press <= '0;
      r_rel   <= '0;
    end else begin
      r_press <= (w_acc & w_s) | w_rep;
      r_rel   <= w_acc & ~w_s;
    end
  end

  assign key_state  = r_state;
  assign keypress   = r_press;
  assign keyrelease = r_rel;
  assign any_press  = |r_press;

endmodule
